// File: rtl/fpnew_inorder_retire.sv
// fpnew_inorder_retire: reorder/retire stage for the FPU top level.
// Allocates an ID per issued op, collects out-of-order completions from
// NumIn opgroup channels into a Depth-entry circular buffer and retires
// results strictly in issue order through one valid/ready port.
//   issue_*      : allocation handshake, issue_id_o = current tail index
//   cpl_*        : per-channel completion handshake (lowest channel wins ties)
//   out_*/result_o/status_o/tag_o : in-order retire port (zero when not valid)
//   occupancy_o/busy_o : allocated entry count / non-empty
//   err_o        : sticky, completion aimed at a non-PENDING entry
module fpnew_inorder_retire #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = 8,
  parameter int unsigned TagWidth = 8,
  parameter int unsigned IdWidth  = $clog2(Depth)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [TagWidth-1:0]       issue_tag_i,
  output logic [IdWidth-1:0]        issue_id_o,
  input  logic [NumIn-1:0]          cpl_valid_i,
  output logic [NumIn-1:0]          cpl_ready_o,
  input  logic [NumIn*IdWidth-1:0]  cpl_id_i,
  input  logic [NumIn*Width-1:0]    cpl_result_i,
  input  logic [NumIn*5-1:0]        cpl_status_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [Width-1:0]          result_o,
  output logic [4:0]                status_o,
  output logic [TagWidth-1:0]       tag_o,
  output logic [IdWidth:0]          occupancy_o,
  output logic                      busy_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } entry_state_e;

  localparam logic [IdWidth:0] PtrOne = 1;

  entry_state_e        state_q  [Depth];
  entry_state_e        state_d  [Depth];
  logic [TagWidth-1:0] tag_q    [Depth];
  logic [TagWidth-1:0] tag_d    [Depth];
  logic [Width-1:0]    result_q [Depth];
  logic [Width-1:0]    result_d [Depth];
  logic [4:0]          status_q [Depth];
  logic [4:0]          status_d [Depth];

  logic [IdWidth:0]    head_q, head_d;
  logic [IdWidth:0]    tail_q, tail_d;
  logic                err_q, err_d;

  logic [IdWidth-1:0]  head_idx, tail_idx;
  logic                full, out_valid, issue_fire, retire_fire;
  logic [IdWidth-1:0]  cpl_id [NumIn];
  logic [NumIn-1:0]    cpl_ready, cpl_bad;

  assign head_idx    = head_q[IdWidth-1:0];
  assign tail_idx    = tail_q[IdWidth-1:0];
  assign full        = (head_idx == tail_idx) && (head_q[IdWidth] != tail_q[IdWidth]);
  assign out_valid   = (state_q[head_idx] == ST_DONE);
  assign issue_fire  = issue_valid_i && !full;
  assign retire_fire = out_valid && out_ready_i;

  always_comb begin
    for (int unsigned i = 0; i < NumIn; i++) begin
      cpl_id[i] = cpl_id_i[i*IdWidth +: IdWidth];
    end
  end

  // A channel is blocked by any lower-indexed valid channel carrying the same ID.
  always_comb begin
    cpl_ready = '0;
    cpl_bad   = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin : g_cpl
      logic dup;
      dup = 1'b0;
      for (int unsigned j = 0; j < i; j++) begin
        if (cpl_valid_i[j] && (cpl_id[j] == cpl_id[i])) dup = 1'b1;
      end
      cpl_ready[i] = (state_q[cpl_id[i]] == ST_PENDING) && !dup;
      cpl_bad[i]   = cpl_valid_i[i] && (state_q[cpl_id[i]] != ST_PENDING);
    end
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    state_d  = state_q;
    tag_d    = tag_q;
    result_d = result_q;
    status_d = status_q;
    err_d    = err_q | (|cpl_bad);
    if (flush_i) begin
      for (int unsigned k = 0; k < Depth; k++) state_d[k] = ST_FREE;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (retire_fire) begin
        state_d[head_idx] = ST_FREE;
        head_d            = head_q + PtrOne;
      end
      if (issue_fire) begin
        state_d[tail_idx] = ST_PENDING;
        tag_d[tail_idx]   = issue_tag_i;
        tail_d            = tail_q + PtrOne;
      end
      for (int unsigned i = 0; i < NumIn; i++) begin
        if (cpl_valid_i[i] && cpl_ready[i]) begin
          state_d[cpl_id[i]]  = ST_DONE;
          result_d[cpl_id[i]] = cpl_result_i[i*Width +: Width];
          status_d[cpl_id[i]] = cpl_status_i[i*5 +: 5];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned k = 0; k < Depth; k++) begin
        state_q[k]  <= ST_FREE;
        tag_q[k]    <= '0;
        result_q[k] <= '0;
        status_q[k] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      err_q    <= err_d;
      state_q  <= state_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign issue_ready_o = !full;
  assign issue_id_o    = tail_idx;
  assign cpl_ready_o   = cpl_ready;
  assign out_valid_o   = out_valid;
  assign result_o      = out_valid ? result_q[head_idx] : '0;
  assign status_o      = out_valid ? status_q[head_idx] : '0;
  assign tag_o         = out_valid ? tag_q[head_idx]    : '0;
  assign occupancy_o   = tail_q - head_q;
  assign busy_o        = (occupancy_o != '0);
  assign err_o         = err_q;

endmodule

// File: tb/tb_fpnew_inorder_retire.sv
module tb_fpnew_inorder_retire;

  localparam int NumIn    = 4;
  localparam int Width    = 64;
  localparam int Depth    = 4;
  localparam int TagWidth = 8;
  localparam int IdWidth  = 2;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     flush_i;
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [TagWidth-1:0]      issue_tag_i;
  logic [IdWidth-1:0]       issue_id_o;
  logic [NumIn-1:0]         cpl_valid_i;
  logic [NumIn-1:0]         cpl_ready_o;
  logic [NumIn*IdWidth-1:0] cpl_id_i;
  logic [NumIn*Width-1:0]   cpl_result_i;
  logic [NumIn*5-1:0]       cpl_status_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [Width-1:0]         result_o;
  logic [4:0]               status_o;
  logic [TagWidth-1:0]      tag_o;
  logic [IdWidth:0]         occupancy_o;
  logic                     busy_o;
  logic                     err_o;

  fpnew_inorder_retire #(
    .NumIn(NumIn), .Width(Width), .Depth(Depth), .TagWidth(TagWidth)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_tag_i(issue_tag_i), .issue_id_o(issue_id_o),
    .cpl_valid_i(cpl_valid_i), .cpl_ready_o(cpl_ready_o), .cpl_id_i(cpl_id_i),
    .cpl_result_i(cpl_result_i), .cpl_status_i(cpl_status_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .occupancy_o(occupancy_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res;
    logic [7:0]  tag;
    logic [4:0]  st;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] plan_res [Depth];
  logic [4:0]  plan_st  [Depth];
  int          mt = 0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_op(input logic [7:0] tag, input logic [63:0] res);
    exp_t e;
    issue_valid_i = 1'b1;
    issue_tag_i   = tag;
    #1;
    chk("issue_ready", issue_ready_o, 1);
    chk("issue_id", issue_id_o, mt);
    plan_res[mt] = res;
    plan_st[mt]  = res[4:0] ^ 5'h15;
    e.res = res; e.tag = tag; e.st = res[4:0] ^ 5'h15;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    issue_valid_i = 1'b0;
    mt = (mt + 1) % Depth;
  endtask

  task automatic complete(input int ch, input int id);
    logic [IdWidth-1:0] idv;
    idv = IdWidth'(id);
    cpl_valid_i[ch] = 1'b1;
    cpl_id_i[ch*IdWidth +: IdWidth] = idv;
    cpl_result_i[ch*Width +: Width] = plan_res[id];
    cpl_status_i[ch*5 +: 5]         = plan_st[id];
    #1;
    chk("cpl_ready", cpl_ready_o[ch], 1);
    @(posedge clk_i);
    #1;
    cpl_valid_i[ch] = 1'b0;
  endtask

  task automatic reset_vals(input logic [63:0] exp_err);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_occupancy", occupancy_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, exp_err);
    chk("rst_result", result_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_issue_id", issue_id_o, 0);
  endtask

  // Retire monitor: inputs only change just after posedge, so the handshake
  // seen at negedge is the one the next posedge will take.
  always @(negedge clk_i) begin
    if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("FAIL retire_unexpected: observed=%0h expected=none", result_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_result", result_o, e.res);
        chk("ret_tag", tag_o, e.tag);
        chk("ret_status", status_o, e.st);
      end
    end
  end

  initial begin
    logic [63:0] held_res;
    logic [7:0]  held_tag;
    int          base;

    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_tag_i = '0;
    cpl_valid_i = '0; cpl_id_i = '0; cpl_result_i = '0; cpl_status_i = '0;
    out_ready_i = 1'b0;
    #2;
    reset_vals(0);
    tick(); tick();
    rst_i = 1'b0;

    // In-order completions and retire
    issue_op(8'hA0, 64'h10);
    issue_op(8'hA1, 64'h11);
    issue_op(8'hA2, 64'h12);
    chk("inorder_occ3", occupancy_o, 3);
    chk("inorder_busy", busy_o, 1);
    out_ready_i = 1'b1;
    complete(0, 0);
    complete(0, 1);
    complete(0, 2);
    tick(); tick(); tick();
    chk("inorder_occ0", occupancy_o, 0);
    chk("inorder_drained", sb.size(), 0);

    // Out-of-order: younger op completes first on ch2
    base = mt;
    issue_op(8'hB0, 64'hA);
    issue_op(8'hB1, 64'hB);
    complete(2, (base + 1) % Depth);
    chk("ooo_hold1", out_valid_o, 0);
    tick();
    chk("ooo_hold2", out_valid_o, 0);
    complete(0, base);
    chk("ooo_valid", out_valid_o, 1);
    chk("ooo_head_res", result_o, 64'hA);
    tick(); tick(); tick();
    chk("ooo_occ0", occupancy_o, 0);

    // Backpressure: head stays stable while not accepted
    out_ready_i = 1'b0;
    base = mt;
    issue_op(8'hC5, 64'hCAFE_0001);
    complete(1, base);
    held_res = sb[0].res;
    held_tag = sb[0].tag;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", out_valid_o, 1);
      chk("bp_result", result_o, held_res);
      chk("bp_tag", tag_o, held_tag);
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("bp_accepted", out_valid_o, 0);
    chk("bp_occ0", occupancy_o, 0);

    // Full: four issues block the fifth
    base = mt;
    for (int k = 0; k < 4; k++) issue_op(8'(8'hD0 + k), 64'h2000 + 64'(k));
    chk("full_ready", issue_ready_o, 0);
    chk("full_occ", occupancy_o, 4);
    issue_valid_i = 1'b1;
    tick();
    issue_valid_i = 1'b0;
    chk("full_blocked_occ", occupancy_o, 4);
    chk("full_blocked_id", issue_id_o, mt);
    complete(3, base);
    chk("full_head_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("full_freed_ready", issue_ready_o, 1);
    chk("full_freed_occ", occupancy_o, 3);
    chk("full_next_id", issue_id_o, base);
    out_ready_i = 1'b1;
    for (int k = 1; k < 4; k++) complete(0, (base + k) % Depth);
    tick(); tick(); tick();
    chk("full_drained", occupancy_o, 0);

    // Same-cycle duplicate completion
    base = mt;
    issue_op(8'hE0, 64'h3000);
    issue_op(8'hE1, 64'h3001);
    issue_op(8'hE2, 64'h3002);
    cpl_valid_i[0] = 1'b1; cpl_id_i[1:0] = IdWidth'(base);
    cpl_result_i[63:0] = plan_res[base]; cpl_status_i[4:0] = plan_st[base];
    cpl_valid_i[1] = 1'b1; cpl_id_i[3:2] = IdWidth'(base);
    cpl_result_i[127:64] = 64'hDEAD; cpl_status_i[9:5] = 5'h1F;
    #1;
    chk("conflict_ready", cpl_ready_o[1:0], 2'b01);
    tick();
    cpl_valid_i[0] = 1'b0;
    chk("conflict_no_err", err_o, 0);
    #1;
    chk("conflict_retry_ready", cpl_ready_o[1], 0);
    tick();
    cpl_valid_i[1] = 1'b0;
    chk("conflict_err", err_o, 1);
    complete(3, (base + 1) % Depth);
    complete(0, (base + 2) % Depth);
    tick(); tick(); tick();
    chk("conflict_drained", occupancy_o, 0);

    // Twenty ops in reverse-order batches, wrapping the pointers
    for (int b = 0; b < 5; b++) begin
      base = mt;
      for (int j = 0; j < 4; j++) issue_op(8'(8'h40 + b*4 + j), 64'h1000 + 64'(b*4 + j));
      for (int j = 3; j >= 1; j--) complete((j + b) % NumIn, (base + j) % Depth);
      chk("wrap_hold", out_valid_o, 0);
      complete(b % NumIn, base);
      tick(); tick(); tick(); tick(); tick();
      chk("wrap_occ0", occupancy_o, 0);
    end
    chk("wrap_drained", sb.size(), 0);

    // Flush
    out_ready_i = 1'b0;
    base = mt;
    issue_op(8'hF0, 64'h5000);
    issue_op(8'hF1, 64'h5001);
    issue_op(8'hF2, 64'h5002);
    complete(2, base);
    chk("flush_pre_valid", out_valid_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sb.delete();
    mt = 0;
    chk("flush_occ", occupancy_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_issue_id", issue_id_o, 0);
    chk("flush_busy", busy_o, 0);
    chk("flush_err_kept", err_o, 1);

    // Asynchronous reset mid-operation
    issue_op(8'h71, 64'h7001);
    issue_op(8'h72, 64'h7002);
    complete(1, 0);
    chk("rst_pre_valid", out_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    reset_vals(0);
    sb.delete();
    mt = 0;
    tick();
    rst_i = 1'b0;
    tick();
    reset_vals(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
